// File: rtl/iomem_ctrl_if.sv
// CPU-side iomem bus between picosoc and the peripheral decoder.
// master = CPU, slave = iomem_ctrl.
interface iomem_ctrl_if;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_ready, iomem_rdata
    );

    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_ready, iomem_rdata
    );
endinterface

// File: rtl/iomem_ctrl.sv
// iomem page decoder and transaction sequencer: one-hot slot select, ready wait
// with timeout, read-data return and error bookkeeping.
module iomem_ctrl #(
    parameter int          NUM_SLOTS = 8,
    parameter logic [7:0]  BASE_PAGE = 8'h03,
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic                          clk,
    input  logic                          resetn,
    iomem_ctrl_if.slave                   bus,
    output logic [NUM_SLOTS-1:0]          slv_sel,
    output logic [23:0]                   slv_addr,
    output logic [3:0]                    slv_wstrb,
    output logic [31:0]                   slv_wdata,
    input  logic [NUM_SLOTS-1:0]          slv_ready,
    input  logic [NUM_SLOTS-1:0][31:0]    slv_rdata,
    input  logic                          err_clr,
    output logic [7:0]                    err_count,
    output logic [31:0]                   err_addr
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                state_q, state_d;
    logic [7:0]            page_off, cnt_q, cnt_d;
    logic [NUM_SLOTS-1:0]  sel_dec, sel_d;
    logic                  mapped, hit, tmo, start, err_inc, rdata_en, ready_d;
    logic [31:0]           rdata_mux, rdata_d;

    // Wrapping subtract: pages below BASE_PAGE land far above NUM_SLOTS.
    assign page_off = bus.iomem_addr[31:24] - BASE_PAGE;

    always_comb begin
        sel_dec = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            sel_dec[i] = (page_off == 8'(i));
    end

    assign mapped = |sel_dec;
    assign hit    = |(slv_ready & slv_sel);
    assign tmo    = (cnt_q == 8'(TIMEOUT - 1));

    always_comb begin
        rdata_mux = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            if (slv_sel[i]) rdata_mux = rdata_mux | slv_rdata[i];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Accept only while the previous ready pulse is not showing; the CPU
    // still holds valid during that cycle.
    always_comb begin
        state_d  = state_q;
        sel_d    = slv_sel;
        cnt_d    = cnt_q;
        start    = 1'b0;
        err_inc  = 1'b0;
        rdata_en = 1'b0;
        rdata_d  = ERR_DATA;
        ready_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.iomem_valid && !bus.iomem_ready) begin
                    if (mapped) begin
                        sel_d   = sel_dec;
                        cnt_d   = '0;
                        start   = 1'b1;
                        state_d = ACCESS;
                    end else begin
                        rdata_en = 1'b1;
                        err_inc  = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            ACCESS: begin
                if (hit) begin
                    rdata_en = 1'b1;
                    rdata_d  = rdata_mux;
                    sel_d    = '0;
                    state_d  = DONE;
                end else if (tmo) begin
                    rdata_en = 1'b1;
                    err_inc  = 1'b1;
                    sel_d    = '0;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                sel_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slv_sel         <= '0;
            cnt_q           <= '0;
            slv_addr        <= '0;
            slv_wstrb       <= '0;
            slv_wdata       <= '0;
            bus.iomem_ready <= 1'b0;
            bus.iomem_rdata <= '0;
        end else begin
            slv_sel         <= sel_d;
            cnt_q           <= cnt_d;
            bus.iomem_ready <= ready_d;
            if (start) begin
                slv_addr  <= bus.iomem_addr[23:0];
                slv_wstrb <= bus.iomem_wstrb;
                slv_wdata <= bus.iomem_wdata;
            end
            if (rdata_en) bus.iomem_rdata <= rdata_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_count <= '0;
            err_addr  <= '0;
        end else if (err_clr) begin
            err_count <= '0;
            err_addr  <= '0;
        end else if (err_inc) begin
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            err_addr <= bus.iomem_addr;
        end
    end
endmodule

// File: doc/iomem_ctrl.md
# iomem_ctrl

Address decoder and transaction sequencer for the SoC peripheral bus (iomem). It sits between the picosoc iomem port and up to NUM_SLOTS peripheral slots. It decodes the address page and drives a one-hot select to a single slot, then waits for that slot's ready. It returns the read data to the CPU and completes the access with a bus error if the slot never responds. This removes per-peripheral address compares and "who drives rdata" logic from the top level, and a dead peripheral can no longer hang the CPU.

## Interface
- NUM_SLOTS, 8: number of peripheral slots (1..16).
- BASE_PAGE, 8'h03: iomem_addr[31:24] value of slot 0; slot i responds at page BASE_PAGE+i.
- TIMEOUT, 255: cycles a selected slot may take before the access is aborted (1..255).
- ERR_DATA, 32'hDEAD_BEEF: read data returned on timeout or unmapped page.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- iomem_valid  in  1  CPU access request.
- iomem_ready  out  1  one-cycle completion strobe to the CPU.
- iomem_wstrb  in  4  byte write strobes; 0 means read.
- iomem_addr  in  32  byte address.
- iomem_wdata  in  32  write data.
- iomem_rdata  out  32  read data; valid while iomem_ready=1.
- slv_sel  out  NUM_SLOTS  one-hot slot select; at most one bit high.
- slv_addr  out  24  latched iomem_addr[23:0], common to all slots.
- slv_wstrb  out  4  latched strobes, common to all slots.
- slv_wdata  out  32  latched write data, common to all slots.
- slv_ready  in  NUM_SLOTS  per-slot done; sampled only for the selected slot.
- slv_rdata  in  32*NUM_SLOTS  per-slot read data; slot i at [32*i+31:32*i].
- err_clr  in  1  synchronous clear of error status.
- err_count  out  8  saturating count of failed accesses.
- err_addr  out  32  address of the most recent failed access.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE with iomem_valid=1:
  - Compute slot = iomem_addr[31:24] - BASE_PAGE.
  - If slot < NUM_SLOTS: latch addr[23:0], wstrb and wdata; set slv_sel[slot]; clear the timeout counter; go to ACCESS.
  - Otherwise (unmapped): set rdata=ERR_DATA, increment err_count, set err_addr=iomem_addr; go to DONE.
- ACCESS, each cycle:
  - If slv_ready[slot]=1: capture that slot's rdata; clear slv_sel; go to DONE.
  - Else if counter == TIMEOUT-1: rdata=ERR_DATA; clear slv_sel; increment err_count; set err_addr; go to DONE.
  - Else: counter++.
- ready and timeout in the same cycle: ready wins and no error is recorded.
- slv_ready bits of non-selected slots are ignored in every state.
- DONE: iomem_ready=1 for exactly one cycle; go to IDLE. iomem_rdata holds until the next capture.
- Writes follow the same path. For writes, rdata is don't-care, except that ERR_DATA is still driven on an error.
- err_count saturates at 255.
- err_clr=1 zeroes err_count and err_addr. If an error occurs in the same cycle as err_clr, the clear wins.
- iomem_valid is not re-sampled until the state returns to IDLE. The CPU holds valid and address stable until it sees ready.

## Timing
- Reset (async assert, sync release): state=IDLE; iomem_ready=0; iomem_rdata=0; slv_sel=0; slv_addr=0; slv_wstrb=0; slv_wdata=0; err_count=0; err_addr=0.
- Reset asserted mid-access drops slv_sel immediately. No iomem_ready is produced for the aborted access.
- Mapped access: valid sampled at edge 0, slv_sel high after edge 0. If the slot asserts slv_ready in k cycles (k≥1 means ready is seen at edge k), iomem_ready is high after edge k+1. Minimum latency is 2 cycles from valid to ready.
- Unmapped access: iomem_ready is high after edge 1.
- Timeout: slv_sel stays high for exactly TIMEOUT cycles; iomem_ready rises in the following cycle.
- slv_addr, slv_wstrb and slv_wdata are stable for the whole time slv_sel is high.
- No back-to-back overlap: at least one IDLE cycle separates successive slv_sel pulses.

## Test plan
- Read slot 0 (addr 0x0300_0004), slave ready 1 cycle after select with rdata 0x1234_5678 → slv_sel=0x01, slv_addr=0x000004, iomem_ready pulse 2 cycles after valid, iomem_rdata=0x1234_5678, err_count=0.
- Write addr 0x0400_0000, wstrb=4'b0011, wdata=0xABCD, slot 1 ready after 5 cycles → slv_sel=0x02 for 5 cycles, slv_wstrb=0011, slv_wdata=0xABCD; iomem_ready 1 cycle later.
- Unmapped page 0x0B (BASE 0x03, 8 slots) → no slv_sel, iomem_ready after 1 cycle, rdata=0xDEAD_BEEF, err_count=1, err_addr=0x0B00_0000.
- Slot 2 never ready, TIMEOUT=255 → slv_sel=0x04 for 255 cycles, then iomem_ready with 0xDEAD_BEEF, err_count++. Repeat with ready arriving exactly on cycle 255 → real data returned, no error.
- Slot 3 ready asserted while slot 5 is selected → ignored; access completes only on slot 5 ready. Then pulse err_clr concurrently with an error → err_count=0.
- Assert resetn=0 mid-ACCESS → slv_sel=0 immediately, all outputs at reset values. After release, a new read to slot 0 completes normally.
